// File: rtl/mouse_link_controller.sv
// mouse_link_controller: frames ESP32 mouse packets from the UART RX byte
// stream, validates each field, enforces an inter-byte timeout, answers
// every packet with ACK/NACK on the UART TX side and tracks link health.
//
// Packet: SYNC, X[7:0], X[8], Y[7:0], Y[8], BTN  (+ CHK when enabled)
//
// Optional feature macro: MOUSE_LINK_CHECKSUM_EN
//   defined   -> 7th byte CHK = XOR of bytes 1..5, commit after CHK
//   undefined -> 6-byte packet, commit after BTN
//
// Ports:
//   clk, rst_n            system clock, asynchronous active-low reset
//   rx_data, rx_valid     byte stream from the UART RX core
//   tx_data, tx_valid     single-entry response (ACK/NACK) to the TX core
//   tx_ready              TX core accepts when tx_valid && tx_ready
//   mouse_x, mouse_y      signed 9-bit deltas of the last good packet
//   buttons               {M,R,L} of the last good packet
//   packet_ready          one-cycle pulse when the outputs update
//   link_up               link healthy
//   err_count             saturating error count
//   led                   {link_up, buttons}

module mouse_link_controller #(
    parameter int unsigned FREQ_HZ    = 27000000,
    parameter int unsigned TIMEOUT_US = 2000,
    parameter logic [7:0]  SYNC_BYTE  = 8'hAA,
    parameter logic [7:0]  ACK_BYTE   = 8'h06,
    parameter logic [7:0]  NACK_BYTE  = 8'h15,
    parameter int unsigned ERR_LIMIT  = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic [8:0] mouse_x,
    output logic [8:0] mouse_y,
    output logic [2:0] buttons,
    output logic       packet_ready,
    output logic       link_up,
    output logic [7:0] err_count,
    output logic [3:0] led
);

    localparam int unsigned TIMEOUT_CYC = FREQ_HZ / 1000000 * TIMEOUT_US;
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [7:0] ERR_LIM = 8'(ERR_LIMIT);

    typedef enum logic [2:0] {
        HUNT  = 3'd0,
        X_LO  = 3'd1,
        X_SGN = 3'd2,
        Y_LO  = 3'd3,
        Y_SGN = 3'd4,
`ifdef MOUSE_LINK_CHECKSUM_EN
        BTN   = 3'd5,
        CHK   = 3'd6
`else
        BTN   = 3'd5
`endif
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [7:0]    xlo_q, xlo_d;
    logic          xsgn_q, xsgn_d;
    logic [7:0]    ylo_q, ylo_d;
    logic          ysgn_q, ysgn_d;
    logic [2:0]    btn_q, btn_d;
    logic [8:0]    mouse_x_q, mouse_x_d;
    logic [8:0]    mouse_y_q, mouse_y_d;
    logic [2:0]    buttons_q, buttons_d;
    logic          packet_ready_q, packet_ready_d;
    logic          link_up_q, link_up_d;
    logic [7:0]    err_count_q, err_count_d;
    logic [7:0]    consec_q, consec_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic          tx_valid_q, tx_valid_d;

    logic good, bad, timeout, err, hs;

    always_comb begin
        state_d        = state_q;
        tmr_d          = tmr_q;
        xlo_d          = xlo_q;
        xsgn_d         = xsgn_q;
        ylo_d          = ylo_q;
        ysgn_d         = ysgn_q;
        btn_d          = btn_q;
        mouse_x_d      = mouse_x_q;
        mouse_y_d      = mouse_y_q;
        buttons_d      = buttons_q;
        packet_ready_d = 1'b0;
        link_up_d      = link_up_q;
        err_count_d    = err_count_q;
        consec_d       = consec_q;
        tx_data_d      = tx_data_q;
        tx_valid_d     = tx_valid_q;
        good           = 1'b0;
        bad            = 1'b0;
        timeout        = 1'b0;
        hs             = tx_valid_q & tx_ready;

        // Gap timer: idle in HUNT, restarted by every byte.
        if (state_q == HUNT || rx_valid) begin
            tmr_d = '0;
        end else if (tmr_q == TMR_LAST) begin
            tmr_d   = '0;
            timeout = 1'b1;
            state_d = HUNT;
        end else begin
            tmr_d = tmr_q + 1'b1;
        end

        if (rx_valid) begin
            unique case (state_q)
                HUNT: begin
                    if (rx_data == SYNC_BYTE) state_d = X_LO;
                end
                X_LO: begin
                    xlo_d   = rx_data;
                    state_d = X_SGN;
                end
                X_SGN: begin
                    if (rx_data[7:1] == 7'd0) begin
                        xsgn_d  = rx_data[0];
                        state_d = Y_LO;
                    end else begin
                        bad     = 1'b1;
                        state_d = HUNT;
                    end
                end
                Y_LO: begin
                    ylo_d   = rx_data;
                    state_d = Y_SGN;
                end
                Y_SGN: begin
                    if (rx_data[7:1] == 7'd0) begin
                        ysgn_d  = rx_data[0];
                        state_d = BTN;
                    end else begin
                        bad     = 1'b1;
                        state_d = HUNT;
                    end
                end
                BTN: begin
                    if (rx_data[7:3] == 5'd0) begin
                        btn_d   = rx_data[2:0];
`ifdef MOUSE_LINK_CHECKSUM_EN
                        state_d = CHK;
`else
                        good    = 1'b1;
                        state_d = HUNT;
`endif
                    end else begin
                        bad     = 1'b1;
                        state_d = HUNT;
                    end
                end
`ifdef MOUSE_LINK_CHECKSUM_EN
                CHK: begin
                    if (rx_data == (xlo_q ^ {7'd0, xsgn_q} ^ ylo_q ^
                                    {7'd0, ysgn_q} ^ {5'd0, btn_q}))
                        good = 1'b1;
                    else
                        bad  = 1'b1;
                    state_d = HUNT;
                end
`endif
                default: state_d = HUNT;
            endcase
        end

        err = bad | timeout;

        // Shadow _d values already hold the final byte at commit time.
        if (good) begin
            mouse_x_d      = {xsgn_d, xlo_d};
            mouse_y_d      = {ysgn_d, ylo_d};
            buttons_d      = btn_d;
            packet_ready_d = 1'b1;
            link_up_d      = 1'b1;
            consec_d       = '0;
        end

        if (err) begin
            if (err_count_q != 8'hFF) err_count_d = err_count_q + 1'b1;
            if (consec_q < ERR_LIM)   consec_d    = consec_q + 1'b1;
            if (timeout || consec_d >= ERR_LIM) link_up_d = 1'b0;
        end

        // Single-entry response slot; a new response is dropped while
        // the slot is busy unless it drains in this very cycle.
        if ((good || err) && (!tx_valid_q || hs)) begin
            tx_valid_d = 1'b1;
            tx_data_d  = good ? ACK_BYTE : NACK_BYTE;
        end else if (hs) begin
            tx_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= HUNT;
            tmr_q          <= '0;
            xlo_q          <= '0;
            xsgn_q         <= 1'b0;
            ylo_q          <= '0;
            ysgn_q         <= 1'b0;
            btn_q          <= '0;
            mouse_x_q      <= '0;
            mouse_y_q      <= '0;
            buttons_q      <= '0;
            packet_ready_q <= 1'b0;
            link_up_q      <= 1'b0;
            err_count_q    <= '0;
            consec_q       <= '0;
            tx_data_q      <= '0;
            tx_valid_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            tmr_q          <= tmr_d;
            xlo_q          <= xlo_d;
            xsgn_q         <= xsgn_d;
            ylo_q          <= ylo_d;
            ysgn_q         <= ysgn_d;
            btn_q          <= btn_d;
            mouse_x_q      <= mouse_x_d;
            mouse_y_q      <= mouse_y_d;
            buttons_q      <= buttons_d;
            packet_ready_q <= packet_ready_d;
            link_up_q      <= link_up_d;
            err_count_q    <= err_count_d;
            consec_q       <= consec_d;
            tx_data_q      <= tx_data_d;
            tx_valid_q     <= tx_valid_d;
        end
    end

    assign mouse_x      = mouse_x_q;
    assign mouse_y      = mouse_y_q;
    assign buttons      = buttons_q;
    assign packet_ready = packet_ready_q;
    assign link_up      = link_up_q;
    assign err_count    = err_count_q;
    assign tx_data      = tx_data_q;
    assign tx_valid     = tx_valid_q;
    assign led          = {link_up_q, buttons_q};

endmodule
